pll_seq_ctrl: RTL and testbench
===============================

Name: pll_seq_ctrl

Overview:
- Sequences the dynamic-divider rPLL that generates the SoC clock.
- Runs on the free-running 27 MHz crystal clock, not the PLL output.
- Drives PLL RESET and the IDSEL/FBDSEL/ODSEL divider codes, waits for LOCK with a timeout and bounded retries, and only then releases the downstream system reset.
- Accepts runtime reconfiguration requests through a valid/ready handshake.

Parameters:
- RST_CYCLES, 16, clock cycles pll_reset is held high per attempt (≥2).
- LOCK_TIMEOUT, 27000, cycles to wait for synchronised lock before an attempt fails (1 ms at 27 MHz).
- SETTLE_CYCLES, 256, cycles lock must stay continuously high before sys_rst_n releases.
- MAX_RETRY, 3, failed attempts allowed after the first before entering FAULT.
- DEF_IDSEL, 6'd0, divider code applied out of reset.
- DEF_FBDSEL, 6'd0, divider code applied out of reset.
- DEF_ODSEL, 6'd0, divider code applied out of reset.

Ports:
- clk  in  1  27 MHz reference clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready at a rising edge.
- cfg_idsel  in  6  new IDSEL code, passed through unmodified.
- cfg_fbdsel  in  6  new FBDSEL code, passed through unmodified.
- cfg_odsel  in  6  new ODSEL code, passed through unmodified.
- pll_lock  in  1  PLL LOCK; asynchronous to clk.
- pll_reset  out  1  to PLL RESET.
- pll_idsel  out  6  to PLL IDSEL.
- pll_fbdsel  out  6  to PLL FBDSEL.
- pll_odsel  out  6  to PLL ODSEL.
- sys_rst_n  out  1  active-low reset for the PLL clock domain; the consumer synchronises it.
- locked  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- state_o  out  3  debug: RST=0, WAIT=1, SETTLE=2, RUN=3, FAULT=4.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values:
  - state=RST; pll_reset=1; sys_rst_n=0; locked=0; fault=0; cfg_ready=0.
  - pll_*sel = DEF_*; retry count=0; counters=0; lock sync flops=0.
- Lock synchroniser: pll_lock passes through a 2-flop synchroniser to give lock_s. Only lock_s is used internally.
- One shared counter (width ≥ clog2 of the largest parameter) is cleared on every state change.
- RST:
  - pll_reset=1, sys_rst_n=0.
  - Leaves after exactly RST_CYCLES edges in the state, going to WAIT with pll_reset=0.
- WAIT:
  - lock_s=1 → SETTLE.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 → attempt failed.
- SETTLE:
  - lock_s=0 → attempt failed.
  - Counter reaches SETTLE_CYCLES-1 → RUN, with sys_rst_n=1 and locked=1 in the same registered update.
- Attempt failed:
  - retry < MAX_RETRY → retry+1, go to RST.
  - Otherwise go to FAULT.
- RUN:
  - cfg_ready=1.
  - lock_s=0 → RST with sys_rst_n=0 and locked=0 on the same edge; retry cleared to 0.
- FAULT:
  - fault=1, pll_reset=1, sys_rst_n=0, cfg_ready=1.
  - Exits only via a cfg handshake or rst_n.
- cfg handshake (RUN or FAULT only):
  - The accepting edge latches cfg_* into pll_*sel, clears retry and goes to RST.
  - On the next cycle: pll_reset=1, sys_rst_n=0, cfg_ready=0.
  - In every other state cfg_ready=0 and cfg_valid is ignored.
- Simultaneous events in RUN: a handshake and a lock loss on the same edge → the handshake wins (new codes latched), next state RST.
- Divider stability: pll_*sel change only on an accepting edge or on reset, never while pll_reset=0.
- Reset mid-operation: rst_n low in any state forces the reset values immediately. Previously latched cfg codes are discarded and DEF_* are restored.
- Nominal bring-up timing: with lock high throughout, edge 1 is the first edge with rst_n=1.
  - RST covers edges 1..RST_CYCLES.
  - WAIT lasts 1 edge.
  - SETTLE lasts SETTLE_CYCLES edges.
  - sys_rst_n rises after edge RST_CYCLES+SETTLE_CYCLES+1.

Test Plan:
1. Defaults, pll_lock=1 from time 0 → pll_reset high for edges 1..16, low from edge 17; sys_rst_n, locked =1 after edge 273; pll_*sel=0.
2. pll_lock stuck 0, LOCK_TIMEOUT=100 → 4 RST pulses of 16 cycles, each followed by a 100-cycle WAIT. Then fault=1, pll_reset=1, cfg_ready=1, and sys_rst_n stays 0.
3. In RUN, pll_lock drops for 10 cycles → sys_rst_n=0 within 3 edges of the drop, state RST, retry=0. Relock gives locked=1 again after RST_CYCLES+SETTLE_CYCLES+1 edges.
4. In RUN, handshake with idsel=8, fbdsel=7, odsel=32 → pll_*sel update on the accept edge and pll_reset=1 the next cycle. cfg_ready=0 until RUN is re-entered. cfg_valid held during RST/WAIT/SETTLE is not accepted.
5. In SETTLE, a lock glitch low at counter=100 → return to RST with retry=1; the full SETTLE count restarts after relock.
6. From FAULT, handshake with new codes and lock=1 → fault=0 next cycle; normal sequence to RUN. rst_n pulsed low mid-WAIT → immediate reset values, pll_*sel back to DEF_*.

Source files
------------

// File: rtl/pll_seq_ctrl.sv
// PLL bring-up sequencer for the dynamic-divider rPLL.
// Runs on the free-running 27 MHz reference clock. It pulses PLL RESET,
// waits for a synchronised LOCK with a timeout and bounded retries, and
// requires LOCK to stay high for a settle window before it releases the
// downstream system reset. New divider codes arrive through a valid/ready
// handshake, which is accepted only in RUN or FAULT.
//
// state  | meaning
// -------+------------------------------------------------------------
// RST    | PLL held in reset for RST_CYCLES edges
// WAIT   | PLL released, waiting up to LOCK_TIMEOUT edges for lock
// SETTLE | lock seen, must stay high for SETTLE_CYCLES edges
// RUN    | system reset released, reconfiguration accepted
// FAULT  | retries exhausted, PLL held in reset until cfg handshake

module pll_seq_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [5:0]  DEF_IDSEL     = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL    = 6'd0,
    parameter logic [5:0]  DEF_ODSEL     = 6'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cfg_valid,
    output logic       o_cfg_ready,
    input  logic [5:0] i_cfg_idsel,
    input  logic [5:0] i_cfg_fbdsel,
    input  logic [5:0] i_cfg_odsel,
    input  logic       i_pll_lock,
    output logic       o_pll_reset,
    output logic [5:0] o_pll_idsel,
    output logic [5:0] o_pll_fbdsel,
    output logic [5:0] o_pll_odsel,
    output logic       o_sys_rst_n,
    output logic       o_locked,
    output logic       o_fault,
    output logic [2:0] o_state
);

    localparam int unsigned MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ?
                                    ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES) :
                                    ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_A + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic               r_lock_s1;
    logic               r_lock_s2;
    logic               r_pll_reset;
    logic               r_sys_rst_n;
    logic               r_locked;
    logic               r_fault;
    logic               r_cfg_ready;
    logic [5:0]         r_idsel;
    logic [5:0]         r_fbdsel;
    logic [5:0]         r_odsel;

    logic w_lock_s;
    logic w_accept;
    logic w_attempt_fail;

    assign w_lock_s = r_lock_s2;
    // cfg_ready is only ever high in RUN/FAULT, so it doubles as the state gate.
    assign w_accept = i_cfg_valid & r_cfg_ready;
    assign w_attempt_fail = ((r_state == ST_WAIT) && !w_lock_s && (r_cnt == TO_LAST)) ||
                            ((r_state == ST_SETTLE) && !w_lock_s);

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= i_pll_lock;
            r_lock_s2 <= r_lock_s1;
        end
    end

    // Sequencer FSM with shared counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_idsel     <= DEF_IDSEL;
            r_fbdsel    <= DEF_FBDSEL;
            r_odsel     <= DEF_ODSEL;
        end else if (w_attempt_fail) begin
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_retry < RETRY_MAX) begin
                r_retry <= r_retry + 1'b1;
                r_state <= ST_RST;
            end else begin
                r_state     <= ST_FAULT;
                r_fault     <= 1'b1;
                r_cfg_ready <= 1'b1;
            end
        end else if (w_accept) begin
            // A handshake beats a simultaneous lock loss in RUN.
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_idsel     <= i_cfg_idsel;
            r_fbdsel    <= i_cfg_fbdsel;
            r_odsel     <= i_cfg_odsel;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state     <= ST_WAIT;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_lock_s) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_locked    <= 1'b1;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= ST_RST;
                        r_cnt       <= '0;
                        r_retry     <= '0;
                        r_pll_reset <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_locked    <= 1'b0;
                        r_cfg_ready <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state     <= ST_RST;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_locked    <= 1'b0;
                    r_fault     <= 1'b0;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_cfg_ready  = r_cfg_ready;
    assign o_pll_reset  = r_pll_reset;
    assign o_pll_idsel  = r_idsel;
    assign o_pll_fbdsel = r_fbdsel;
    assign o_pll_odsel  = r_odsel;
    assign o_sys_rst_n  = r_sys_rst_n;
    assign o_locked     = r_locked;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl with a short lock timeout so the
// retry/FAULT path stays quick. Outputs are sampled 1 ns after each edge.

module tb_pll_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [5:0] cfg_idsel = 6'd0;
    logic [5:0] cfg_fbdsel = 6'd0;
    logic [5:0] cfg_odsel = 6'd0;
    logic       pll_lock = 1'b1;
    logic       cfg_ready;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [2:0] state;

    int n_chk = 0;
    int n_fail = 0;

    pll_seq_ctrl #(
        .RST_CYCLES    (16),
        .LOCK_TIMEOUT  (100),
        .SETTLE_CYCLES (256),
        .MAX_RETRY     (3),
        .DEF_IDSEL     (6'd0),
        .DEF_FBDSEL    (6'd0),
        .DEF_ODSEL     (6'd0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_idsel  (cfg_idsel),
        .i_cfg_fbdsel (cfg_fbdsel),
        .i_cfg_odsel  (cfg_odsel),
        .i_pll_lock   (pll_lock),
        .o_pll_reset  (pll_reset),
        .o_pll_idsel  (pll_idsel),
        .o_pll_fbdsel (pll_fbdsel),
        .o_pll_odsel  (pll_odsel),
        .o_sys_rst_n  (sys_rst_n),
        .o_locked     (locked),
        .o_fault      (fault),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] sel3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return {14'd0, a, b, c};
    endfunction

    // Edges (counted on from start) until locked rises, capped.
    task automatic wait_locked(input int start, output int edges);
        edges = start;
        while (!locked && edges < 1000) begin
            step(1);
            edges++;
        end
    endtask

    task automatic handshake(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        cfg_idsel  = a;
        cfg_fbdsel = b;
        cfg_odsel  = c;
        cfg_valid  = 1'b1;
        step(1);
        cfg_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        int lows;
        int rises;
        int fault_edge;
        logic prev;

        // Reset values
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
        chk("rst_flags", {29'd0, locked, fault, cfg_ready}, 0);
        chk("rst_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), 0);
        rst_n = 1'b1;

        // Nominal bring-up with lock high from time 0
        step(15);
        chk("t1_rst_e15_state", 32'(state), 0);
        chk("t1_rst_e15_pll_reset", 32'(pll_reset), 1);
        step(1);
        chk("t1_e16_pll_reset", 32'(pll_reset), 0);
        chk("t1_e16_state", 32'(state), 1);
        step(1);
        chk("t1_e17_state", 32'(state), 2);
        step(255);
        chk("t1_e272_sys_rst_n", 32'(sys_rst_n), 0);
        chk("t1_e272_state", 32'(state), 2);
        step(1);
        chk("t1_e273_sys_rst_n", 32'(sys_rst_n), 1);
        chk("t1_e273_locked", 32'(locked), 1);
        chk("t1_e273_state", 32'(state), 3);
        chk("t1_e273_cfg_ready", 32'(cfg_ready), 1);
        chk("t1_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), 0);

        // Lock loss in RUN for 10 cycles, then relock
        pll_lock = 1'b0;
        n = 0;
        while (sys_rst_n && n < 10) begin
            step(1);
            n++;
        end
        chk("t3_drop_latency", 32'(n), 3);
        chk("t3_state", 32'(state), 0);
        chk("t3_locked", 32'(locked), 0);
        chk("t3_pll_reset", 32'(pll_reset), 1);
        step(7);
        pll_lock = 1'b1;
        wait_locked(7, n);
        chk("t3_relock_edges", 32'(n), 273);

        // Handshake in RUN; valid held through RST/WAIT/SETTLE must be ignored
        chk("t4_ready_in_run", 32'(cfg_ready), 1);
        cfg_idsel = 6'd8;
        cfg_fbdsel = 6'd7;
        cfg_odsel = 6'd32;
        cfg_valid = 1'b1;
        step(1);
        chk("t4_accept_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), sel3(6'd8, 6'd7, 6'd32));
        chk("t4_accept_pll_reset", 32'(pll_reset), 1);
        chk("t4_accept_cfg_ready", 32'(cfg_ready), 0);
        chk("t4_accept_sys_rst_n", 32'(sys_rst_n), 0);
        chk("t4_accept_state", 32'(state), 0);
        cfg_idsel = 6'd1;
        cfg_fbdsel = 6'd2;
        cfg_odsel = 6'd3;
        bad = 0;
        for (int i = 0; i < 272; i++) begin
            step(1);
            if (sel3(pll_idsel, pll_fbdsel, pll_odsel) != sel3(6'd8, 6'd7, 6'd32) || cfg_ready)
                bad++;
        end
        chk("t4_ignored_while_busy", 32'(bad), 0);
        chk("t4_e272_state", 32'(state), 2);
        cfg_valid = 1'b0;
        step(1);
        chk("t4_e273_state", 32'(state), 3);
        chk("t4_e273_cfg_ready", 32'(cfg_ready), 1);
        chk("t4_e273_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), sel3(6'd8, 6'd7, 6'd32));

        // SETTLE lock glitch at counter=100 restarts the full sequence
        handshake(6'd8, 6'd7, 6'd32);
        step(115);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        chk("t5_e117_state", 32'(state), 2);
        step(1);
        chk("t5_e118_state", 32'(state), 0);
        chk("t5_e118_pll_reset", 32'(pll_reset), 1);
        wait_locked(0, n);
        chk("t5_relock_edges", 32'(n), 273);

        // Lock stuck low: four attempts then FAULT
        pll_lock = 1'b0;
        n = 0;
        while (sys_rst_n && n < 10) begin
            step(1);
            n++;
        end
        chk("t2_drop_latency", 32'(n), 3);
        lows = 0;
        rises = 0;
        bad = 0;
        fault_edge = 0;
        prev = 1'b1;
        for (int e = 1; e <= 600 && fault_edge == 0; e++) begin
            step(1);
            if (!pll_reset) lows++;
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
            if (sys_rst_n) bad++;
            if (fault) fault_edge = e;
        end
        chk("t2_low_cycles", 32'(lows), 400);
        chk("t2_reset_pulses", 32'(rises), 4);
        chk("t2_fault_edge", 32'(fault_edge), 464);
        chk("t2_sys_rst_n_high", 32'(bad), 0);
        chk("t2_state", 32'(state), 4);
        chk("t2_pll_reset", 32'(pll_reset), 1);
        chk("t2_cfg_ready", 32'(cfg_ready), 1);
        step(50);
        chk("t2_fault_held", {30'd0, fault, sys_rst_n}, 2);

        // Recovery from FAULT via handshake
        pll_lock = 1'b1;
        handshake(6'd5, 6'd9, 6'd17);
        chk("t6_fault_cleared", 32'(fault), 0);
        chk("t6_state", 32'(state), 0);
        chk("t6_cfg_ready", 32'(cfg_ready), 0);
        chk("t6_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), sel3(6'd5, 6'd9, 6'd17));
        wait_locked(0, n);
        chk("t6_relock_edges", 32'(n), 273);

        // Async reset mid-WAIT restores defaults immediately
        pll_lock = 1'b0;
        handshake(6'd1, 6'd2, 6'd3);
        step(36);
        chk("t6_mid_wait_state", 32'(state), 1);
        chk("t6_mid_wait_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), sel3(6'd1, 6'd2, 6'd3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_state", 32'(state), 0);
        chk("t6_async_pll_reset", 32'(pll_reset), 1);
        chk("t6_async_sel", sel3(pll_idsel, pll_fbdsel, pll_odsel), 0);
        chk("t6_async_flags", {28'd0, sys_rst_n, locked, fault, cfg_ready}, 0);
        #10;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
